// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : shared types for the datapath ALU (shift op codes, FSM states)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        SHL  = 3'd0,
        SHR  = 3'd1,
        SHRA = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4
    } shift_op_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iterative_shift_unit_shift_step.sv
// ----------------------------------------------------------------------------
// shift_step : one combinational shift/rotate step of 1..STEP positions
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       op,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] acc_next
);

    // s never exceeds WIDTH/2, so the complementary rotate shift stays in range
    always_comb begin
        acc_next = acc;
        case (shift_op_t'(op))
            SHL:     acc_next = acc << s;
            SHR:     acc_next = acc >> s;
            SHRA:    acc_next = $unsigned($signed(acc) >>> s);
            ROL:     acc_next = (acc << s) | (acc >> (WIDTH - int'(s)));
            ROR:     acc_next = (acc >> s) | (acc << (WIDTH - int'(s)));
            default: acc_next = acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// ----------------------------------------------------------------------------
// iterative_shift_unit : multi-cycle shift/rotate with start/busy/done handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iterative_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               SW         = $clog2(STEP + 1);
    localparam logic [CNT_W-1:0] C_STEP_CNT = CNT_W'(STEP);

    shift_state_t     r_state;
    shift_state_t     w_state_next;
    logic [WIDTH-1:0] r_acc, w_acc_next, w_step_acc;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic [2:0]       r_op, w_op_next;
    logic [CNT_W-1:0] r_rem, w_rem_next, w_amt;
    logic [SW-1:0]    w_s;
    logic             r_busy, r_done, w_busy_next, w_done_next;
    logic             w_unused_b;

    // Only the low bits of b matter; larger amounts wrap modulo WIDTH
    assign w_amt      = b[CNT_W-1:0];
    assign w_unused_b = ^b[WIDTH-1:CNT_W];
    assign w_s        = (r_rem >= C_STEP_CNT) ? SW'(STEP) : SW'(r_rem);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_shift_step (
        .acc      (r_acc),
        .op       (r_op),
        .s        (w_s),
        .acc_next (w_step_acc)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_state_next = ST_SHIFT;
                ST_SHIFT: if (r_rem == '0) w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_acc_next    = r_acc;
        w_op_next     = r_op;
        w_rem_next    = r_rem;
        w_result_next = r_result;
        w_done_next   = 1'b0;
        w_busy_next   = (w_state_next == ST_SHIFT);
        if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_acc_next = a;
                        w_op_next  = op;
                        // Illegal codes finish immediately as a pass-through
                        w_rem_next = is_legal_op(op) ? w_amt : '0;
                    end
                end
                ST_SHIFT: begin
                    if (r_rem != '0) begin
                        w_acc_next = w_step_acc;
                        w_rem_next = r_rem - CNT_W'(w_s);
                    end else begin
                        w_result_next = r_acc;
                        w_done_next   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_acc    <= '0;
            r_op     <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_acc    <= w_acc_next;
            r_op     <= w_op_next;
            r_rem    <= w_rem_next;
            r_result <= w_result_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_iterative_shift_unit : scoreboard bench for STEP=1 and STEP=4 instances
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_iterative_shift_unit;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start1 = 1'b0, start4 = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q4[$];
    logic [31:0] last1 = '0, last4 = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    iterative_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clock(clock), .clear(clear), .start(start1), .flush(flush),
        .op(op), .a(a), .b(b), .busy(busy1), .done(done1), .result(result1)
    );

    iterative_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clock(clock), .clear(clear), .start(start4), .flush(flush),
        .op(op), .a(a), .b(b), .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] av, input int amt);
        logic [63:0] dbl;
        dbl = {av, av};
        case (o)
            3'd0: return av << amt;
            3'd1: return av >> amt;
            3'd2: return $unsigned($signed(av) >>> amt);
            3'd3: begin dbl = dbl << amt; return dbl[63:32]; end
            3'd4: begin dbl = dbl >> amt; return dbl[31:0]; end
            default: return av;
        endcase
    endfunction

    // Called at a negedge; start is sampled at the following posedge
    task automatic issue(input int sel, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input bit push);
        exp_t e;
        int   amt;
        int   step;
        op = o; a = av; b = bv;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        if (push) begin
            amt   = int'(bv[4:0]);
            step  = (sel == 1) ? 1 : 4;
            e.res = ref_shift(o, av, amt);
            e.t0  = cyc;
            e.lat = (o > 3'd4) ? 1 : (amt + step - 1) / step + 1;
            if (sel == 1) q1.push_back(e); else q4.push_back(e);
        end
    endtask

    task automatic wait_done(input int sel, output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if ((sel == 1) ? done1 : done4) seen = 1'b1;
            else if ((sel == 1) ? busy1 : busy4) busy_cnt++;
        end
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (clear && done1) begin
            if (q1.size() == 0) check_val("unexpected_done1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check_val("result1", result1, e.res);
                check_val("latency1", 32'(cyc - e.t0), 32'(e.lat));
                last1 = e.res;
            end
        end
        if (clear && done4) begin
            if (q4.size() == 0) check_val("unexpected_done4", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                check_val("result4", result4, e.res);
                check_val("latency4", 32'(cyc - e.t0), 32'(e.lat));
                last4 = e.res;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int bc;
        repeat (3) @(negedge clock);
        check_val("rst_busy1", 32'(busy1), 32'd0);
        check_val("rst_done1", 32'(done1), 32'd0);
        check_val("rst_result1", result1, 32'd0);
        check_val("rst_result4", result4, 32'd0);
        clear = 1'b1;
        @(negedge clock);

        issue(1, SHL, 32'hFFFF_FF0A, 32'd7, 1'b1);
        wait_done(1, bc);
        check_val("busy_cycles", 32'(bc), 32'd8);
        check_val("shl_const", result1, 32'hFFFF_8500);

        // Back-to-back: each new start lands in the cycle done is high
        issue(1, SHRA, 32'h8000_0000, 32'd4, 1'b1);
        wait_done(1, bc);
        check_val("shra_const", result1, 32'hF800_0000);
        issue(1, ROR, 32'h0000_000F, 32'd4, 1'b1);
        wait_done(1, bc);
        check_val("ror_const", result1, 32'hF000_0000);
        issue(1, ROL, 32'h8000_0001, 32'd1, 1'b1);
        wait_done(1, bc);
        check_val("rol_const", result1, 32'h0000_0003);
        issue(1, SHL, 32'h0000_0001, 32'd35, 1'b1);
        wait_done(1, bc);
        check_val("wrap_const", result1, 32'h0000_0008);

        @(negedge clock);
        issue(4, SHR, 32'h8000_0000, 32'd31, 1'b1);
        wait_done(4, bc);
        check_val("step4_const", result4, 32'h0000_0001);

        issue(1, ROL, 32'h1234_5678, 32'd0, 1'b1);
        wait_done(1, bc);
        issue(4, SHRA, 32'h9234_5678, 32'd32, 1'b1);
        wait_done(4, bc);
        issue(1, 3'd7, 32'hCAFE_BABE, 32'd5, 1'b1);
        wait_done(1, bc);
        check_val("illegal_pass", result1, 32'hCAFE_BABE);

        for (int i = 0; i < 10; i++) begin
            issue(1, 3'($urandom_range(0, 5)), $urandom, $urandom, 1'b1);
            wait_done(1, bc);
            issue(4, 3'($urandom_range(0, 5)), $urandom, $urandom, 1'b1);
            wait_done(4, bc);
        end

        // Flush mid-operation: no done, result keeps its previous value
        @(negedge clock);
        issue(1, SHL, 32'h0000_0F0F, 32'd20, 1'b0);
        repeat (4) @(negedge clock);
        flush = 1'b1;
        issue(1, SHR, 32'hFFFF_FFFF, 32'd3, 1'b0);
        flush = 1'b0;
        check_val("flush_busy", 32'(busy1), 32'd0);
        check_val("flush_done", 32'(done1), 32'd0);
        check_val("flush_result", result1, last1);
        repeat (30) @(negedge clock);

        // Start while busy is ignored
        issue(1, SHR, 32'hF0F0_F0F0, 32'd10, 1'b1);
        repeat (3) @(negedge clock);
        issue(1, SHL, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done(1, bc);
        check_val("busy_ignore", result1, 32'h003C_3C3C);
        repeat (20) @(negedge clock);

        // Asynchronous clear mid-operation
        issue(1, SHL, 32'h0000_0001, 32'd20, 1'b0);
        repeat (2) @(negedge clock);
        #2 clear = 1'b0;
        #1;
        check_val("clr_busy", 32'(busy1), 32'd0);
        check_val("clr_done", 32'(done1), 32'd0);
        check_val("clr_result1", result1, 32'd0);
        check_val("clr_result4", result4, 32'd0);
        last1 = '0; last4 = '0;
        @(negedge clock);
        clear = 1'b1;
        repeat (30) @(negedge clock);
        check_val("clr_no_done", 32'(done1), 32'd0);

        issue(1, ROR, 32'h0000_0001, 32'd1, 1'b1);
        wait_done(1, bc);
        check_val("recover", result1, 32'h8000_0000);
        repeat (5) @(negedge clock);
        check_val("q1_empty", 32'(q1.size()), 32'd0);
        check_val("q4_empty", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
- Multi-cycle shift/rotate unit for the datapath ALU, replacing a single-cycle SHL path.
- Covers SHL, SHR, SHRA, ROL and ROR at parametrised width, shifting STEP bits per cycle.
- Uses a start/busy/done handshake, so the control sequencer stalls its Z-load step until done.
- The result feeds the Z register input; the operand comes from Y/bus, and the amount comes from the bus register.

Parameters:
WIDTH, 32, operand/result width in bits; power of 2, >= 8
STEP, 1, maximum bit positions shifted per cycle; power of 2, 1..WIDTH/2
CNT_W, $clog2(WIDTH), width of the effective shift amount (derived; do not override)

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous reset, active-low
start  in  1  request; sampled only in IDLE
flush  in  1  synchronous abort; priority over start
op  in  3  operation code (package enum)
a  in  WIDTH  value to shift
b  in  WIDTH  shift amount; only b[CNT_W-1:0] used
busy  out  1  high while in SHIFT
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  shifted value; held until the next done

Behaviour:
- States: IDLE, SHIFT. Reset (clear low, asynchronous): state=IDLE, busy=0, done=0, result=0, internal acc=0, remaining=0.
- Effective amount amt = b[CNT_W-1:0]. Amounts >= WIDTH wrap modulo WIDTH (b=35 at WIDTH=32 gives 3).
- IDLE & start & !flush at edge k: acc<=a, op captured, remaining<=amt, state<=SHIFT, busy<=1. done cleared this edge.
- SHIFT, remaining!=0: shift acc by s=min(STEP,remaining), then remaining<=remaining-s.
  - SHL: zero fill.
  - SHR: zero fill.
  - SHRA: sign fill from acc MSB.
  - ROL/ROR: circular.
- SHIFT, remaining==0: result<=acc, done<=1 for exactly one cycle, busy<=0, state<=IDLE.
- Latency: done is high in the cycle after edge k+n+1, where n=ceil(amt/STEP). For amt=0, n=0 and done follows edge k+1.
- Illegal op code: captured as pass-through. remaining is forced to 0, so result=a and the latency equals that of amt=0.
- start while busy: ignored, with no queueing.
- start in the cycle done is high: accepted (state is IDLE). done drops next cycle.
- flush in any state: state<=IDLE, busy<=0, done<=0 next edge. result keeps its previous value. flush+start in the same cycle means flush wins and start is dropped.
- a/b/op changing during SHIFT: no effect, because operands were captured at start.
- clear asserted mid-operation: immediate return to reset values. No done is produced for the aborted request.
- Inputs are registered and there is no combinational path to any output; all outputs are flop-driven.

Decomposition:
- Shared package alu_pkg holds:
  - the shift_op_t enum: SHL=3'd0, SHR=3'd1, SHRA=3'd2, ROL=3'd3, ROR=3'd4, others illegal;
  - the state enum;
  - localparam DEFAULT_WIDTH=32.
- Sub-module shift_step is purely combinational: it takes acc, op and s (1..STEP) and returns the next acc. It keeps the barrel logic out of the FSM and lets the step be unit-tested alone.

Test Plan:
- WIDTH=32, STEP=1, SHL, a=32'hFFFF_FF0A, b=7 -> result=32'hFFFF_8500; done pulses 8 cycles after the start edge; busy high for 8 cycles.
- STEP=1, four back-to-back requests -> each must produce the listed result with the listed latency:
  - SHRA, a=32'h8000_0000, b=4 -> 32'hF800_0000, done after 5 cycles.
  - ROR, a=32'h0000_000F, b=4 -> 32'hF000_0000.
  - ROL, a=32'h8000_0001, b=1 -> 32'h0000_0003.
- STEP=4, SHR, a=32'h8000_0000, b=31 -> 32'h0000_0001; done after 9 cycles (partial final step of 3).
- b=35, SHL, a=1 -> 32'h0000_0008, confirming modulo wrap.
- b=0 -> result=a, done after 1 cycle.
- Illegal op=3'd7 -> result=a, done after 1 cycle.
- Abort and reset mid-operation:
  - Start SHL amt=20 (STEP=1), assert flush at cycle 5 -> no done, busy=0 next edge, result unchanged.
  - Start again, pull clear low at cycle 3 -> all outputs 0 immediately.
  - Start asserted during busy -> ignored, no extra done.
